l2_fill_ctrl: RTL and testbench
===============================

# l2_fill_ctrl

Write-side controller for the L2 cache ways: it owns each way's write port (WRA/WRD/WRM/WR/CLR/ALL). It services read-miss fills from the memory bus, invalidates entries on CPU write snoops, and sweeps all indices on a flush request. It sits between the L2 lookup logic (which raises misses) and the memory bus interface.

## Interface
- FLUSH_ENTRIES, 1024, number of way indices swept by a flush (index = WRA[11:2])
- CLK  in  1  system clock, all logic rising-edge
- nRST  in  1  asynchronous active-low reset
- MissReq  in  1  level; lookup missed, held until FillDone
- MissA  in  26 [27:2]  miss address, stable while MissReq high
- MemReq  out  1  memory read request, held until MemRDY
- MemA  out  26 [27:2]  memory read address
- MemRDY  in  1  one-cycle pulse, MemD valid
- MemD  in  32  memory read data
- SnpWR  in  1  one-cycle pulse, CPU write observed
- SnpA  in  26 [27:2]  snooped write address
- FlushReq  in  1  one-cycle pulse, invalidate whole L2
- WRA  out  26 [27:2]  way write address
- WRD  out  32  way write data
- WRM  out  4  byte mask, always 4'hF on fills
- WR  out  1  way write strobe, one cycle per write
- CLR  out  1  write stores Valid=0
- ALL  out  1  high on flush-sweep writes
- Busy  out  1  high in any state except IDLE
- FillDone  out  1  one-cycle pulse, fill (or dropped fill) complete

## Operation
- States: IDLE, FETCH, FILL, FLUSH.
- IDLE: priority FlushReq > SnpWR > MissReq.
  - FlushReq -> FLUSH, counter=0.
  - SnpWR -> one invalidate write (WR=1, CLR=1, WRA=SnpA), stay IDLE.
  - MissReq -> latch MissA, assert MemReq/MemA, -> FETCH, stale=0.
- FETCH: MemReq held.
  - SnpWR is serviced as an invalidate in the same cycle; write port is otherwise idle.
  - If SnpA==latched MissA, set stale=1.
  - On MemRDY: latch MemD, drop MemReq, -> FILL.
  - MemRDY and matching SnpWR in the same cycle also set stale.
- FILL: one write: WR=1, WRA=miss address, WRD=data, WRM=F, CLR=stale. Pulse FillDone, -> IDLE.
  - A SnpWR arriving in FILL is queued: one pending-snoop register, written in the following IDLE cycle ahead of any new miss.
  - If the queued SnpA equals the fill address, the fill is written with CLR=1.
- FLUSH: WR=1, CLR=1, ALL=1, WRA[11:2]=counter, WRA[27:12]=0; counter+1 each cycle.
  - After index FLUSH_ENTRIES-1 -> IDLE (1024 write cycles).
  - SnpWR during FLUSH is ignored.
  - FlushReq during FLUSH restarts the counter at 0.
  - MissReq is not sampled until IDLE.
- FlushReq during FETCH: recorded as pending. The fill completes with CLR=1 (data discarded), FillDone pulses, then FLUSH starts.
- A second SnpWR while the pending-snoop register is full: not permitted (the CPU bus cannot issue back-to-back writes); the bench asserts this never happens.
- Counter is 10 bits; wraps only via the state exit, never past FLUSH_ENTRIES-1.

## Timing
- All outputs are registered.
- Reset values: WR=0, CLR=0, ALL=0, MemReq=0, Busy=0, FillDone=0, WRA=0, WRD=0, WRM=0, MemA=0, state=IDLE, stale=0, pending flags clear.
- Miss latency:
  - MissReq sampled at edge N -> MemReq high after N.
  - MemRDY at edge M -> WR/FillDone high after M+1.
  - Requester sees FillDone and drops MissReq; the controller ignores MissReq in the cycle after FillDone.
- Snoop invalidate in IDLE/FETCH: WR high the cycle after SnpWR is sampled.
- Flush: first WR the cycle after FlushReq; Busy falls the cycle after the last write.
- nRST asserted mid-operation: immediate return to reset values. An outstanding MemRDY after reset release is ignored in IDLE.

## Test plan
- Reset with FlushReq/MissReq active -> all outputs 0; after release, no WR until a new request.
- Miss at MissA=26'h0012345, MemRDY after 3 cycles with MemD=32'hDEADBEEF -> one WR with WRA=0012345, WRD=DEADBEEF, WRM=F, CLR=0; FillDone 1 cycle.
- Miss at A, SnpWR to A during FETCH -> invalidate write to A in FETCH, then fill write to A with CLR=1; SnpWR to B≠A -> fill has CLR=0.
- FlushReq in IDLE -> exactly 1024 consecutive WR cycles, CLR=ALL=1, WRA[11:2] 0..1023; Busy high 1024 cycles.
- FlushReq during FETCH, MissReq held -> fill written with CLR=1, FillDone, then 1024-cycle sweep; a SnpWR during the sweep produces no extra WR.
- SnpWR coincident with FILL, same address -> fill CLR=1, then one extra invalidate write; different address -> fill CLR=0, invalidate next cycle.

Source files
------------

// File: rtl/l2_fill_ctrl.sv
// l2_fill_ctrl: owns the L2 way write port. Serialises read-miss fills,
// snoop invalidates and whole-cache flush sweeps onto one registered write port.
module l2_fill_ctrl #(
  parameter int FLUSH_ENTRIES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_req,
  input  logic [25:0] miss_a,
  output logic        mem_req,
  output logic [25:0] mem_a,
  input  logic        mem_rdy,
  input  logic [31:0] mem_d,
  input  logic        snp_wr,
  input  logic [25:0] snp_a,
  input  logic        flush_req,
  output logic [25:0] wra,
  output logic [31:0] wrd,
  output logic [3:0]  wrm,
  output logic        wr,
  output logic        clr,
  output logic        all,
  output logic        busy,
  output logic        fill_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;
  localparam logic [9:0] LAST_IDX = 10'(FLUSH_ENTRIES - 1);

  logic [1:0]  state_reg, state_next;
  logic [25:0] miss_addr_reg, miss_addr_next;
  logic [31:0] data_reg, data_next;
  logic        stale_reg, stale_next;
  logic        pend_snp_reg, pend_snp_next;
  logic [25:0] pend_snp_a_reg, pend_snp_a_next;
  logic        pend_flush_reg, pend_flush_next;
  logic [9:0]  cnt_reg, cnt_next;

  logic        mem_req_reg, mem_req_next;
  logic [25:0] mem_a_reg, mem_a_next;
  logic [25:0] wra_reg, wra_next;
  logic [31:0] wrd_reg, wrd_next;
  logic [3:0]  wrm_reg, wrm_next;
  logic        wr_reg, wr_next;
  logic        clr_reg, clr_next;
  logic        all_reg, all_next;
  logic        busy_reg, busy_next;
  logic        fill_done_reg, fill_done_next;
  logic        snp_hit;

  always_comb begin
    state_next      = state_reg;
    miss_addr_next  = miss_addr_reg;
    data_next       = data_reg;
    stale_next      = stale_reg;
    pend_snp_next   = pend_snp_reg;
    pend_snp_a_next = pend_snp_a_reg;
    pend_flush_next = pend_flush_reg;
    cnt_next        = cnt_reg;
    mem_req_next    = mem_req_reg;
    mem_a_next      = mem_a_reg;
    wra_next        = wra_reg;
    wrd_next        = wrd_reg;
    wrm_next        = wrm_reg;
    wr_next         = 1'b0;
    clr_next        = 1'b0;
    all_next        = 1'b0;
    fill_done_next  = 1'b0;
    snp_hit         = snp_wr && (snp_a == miss_addr_reg);

    case (state_reg)
      IDLE: begin
        if (flush_req || pend_flush_reg) begin
          // A flush wipes everything, so a queued snoop is redundant.
          state_next      = FLUSH;
          cnt_next        = '0;
          pend_flush_next = 1'b0;
          pend_snp_next   = 1'b0;
          wr_next         = 1'b1;
          clr_next        = 1'b1;
          all_next        = 1'b1;
          wra_next        = '0;
          wrm_next        = 4'hF;
        end else if (snp_wr) begin
          wr_next  = 1'b1;
          clr_next = 1'b1;
          wra_next = snp_a;
          wrm_next = 4'hF;
        end else if (pend_snp_reg) begin
          pend_snp_next = 1'b0;
          wr_next       = 1'b1;
          clr_next      = 1'b1;
          wra_next      = pend_snp_a_reg;
          wrm_next      = 4'hF;
        end else if (miss_req && !fill_done_reg) begin
          // The requester is still dropping MissReq in the cycle after FillDone.
          state_next     = FETCH;
          miss_addr_next = miss_a;
          mem_req_next   = 1'b1;
          mem_a_next     = miss_a;
          stale_next     = 1'b0;
        end
      end

      FETCH: begin
        if (snp_wr) begin
          wr_next  = 1'b1;
          clr_next = 1'b1;
          wra_next = snp_a;
          wrm_next = 4'hF;
        end
        if (snp_hit) begin
          stale_next = 1'b1;
        end
        if (flush_req) begin
          pend_flush_next = 1'b1;
        end
        if (mem_rdy) begin
          data_next    = mem_d;
          mem_req_next = 1'b0;
          state_next   = FILL;
        end
      end

      FILL: begin
        wr_next        = 1'b1;
        wra_next       = miss_addr_reg;
        wrd_next       = data_reg;
        wrm_next       = 4'hF;
        clr_next       = stale_reg || snp_hit || pend_flush_reg || flush_req;
        fill_done_next = 1'b1;
        state_next     = IDLE;
        if (flush_req) begin
          pend_flush_next = 1'b1;
        end
        // The port is busy with the fill; park the snoop for the next IDLE cycle.
        if (snp_wr) begin
          pend_snp_next   = 1'b1;
          pend_snp_a_next = snp_a;
        end
      end

      FLUSH: begin
        if (flush_req) begin
          cnt_next = '0;
          wr_next  = 1'b1;
          clr_next = 1'b1;
          all_next = 1'b1;
          wra_next = '0;
        end else if (cnt_reg == LAST_IDX) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 10'd1;
          wr_next  = 1'b1;
          clr_next = 1'b1;
          all_next = 1'b1;
          wra_next = {16'd0, cnt_next};
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      miss_addr_reg  <= '0;
      data_reg       <= '0;
      stale_reg      <= 1'b0;
      pend_snp_reg   <= 1'b0;
      pend_snp_a_reg <= '0;
      pend_flush_reg <= 1'b0;
      cnt_reg        <= '0;
      mem_req_reg    <= 1'b0;
      mem_a_reg      <= '0;
      wra_reg        <= '0;
      wrd_reg        <= '0;
      wrm_reg        <= '0;
      wr_reg         <= 1'b0;
      clr_reg        <= 1'b0;
      all_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      fill_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      miss_addr_reg  <= miss_addr_next;
      data_reg       <= data_next;
      stale_reg      <= stale_next;
      pend_snp_reg   <= pend_snp_next;
      pend_snp_a_reg <= pend_snp_a_next;
      pend_flush_reg <= pend_flush_next;
      cnt_reg        <= cnt_next;
      mem_req_reg    <= mem_req_next;
      mem_a_reg      <= mem_a_next;
      wra_reg        <= wra_next;
      wrd_reg        <= wrd_next;
      wrm_reg        <= wrm_next;
      wr_reg         <= wr_next;
      clr_reg        <= clr_next;
      all_reg        <= all_next;
      busy_reg       <= busy_next;
      fill_done_reg  <= fill_done_next;
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_a     = mem_a_reg;
  assign wra       = wra_reg;
  assign wrd       = wrd_reg;
  assign wrm       = wrm_reg;
  assign wr        = wr_reg;
  assign clr       = clr_reg;
  assign all       = all_reg;
  assign busy      = busy_reg;
  assign fill_done = fill_done_reg;

endmodule

// File: tb/tb_l2_fill_ctrl.sv
// Bench for l2_fill_ctrl: vector table of fill/snoop scenarios, directed
// flush and reset sequences, and randomized misses against a write-list model.
module tb_l2_fill_ctrl;

  localparam int FLUSH_N = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_req = 1'b0;
  logic [25:0] miss_a = '0;
  logic        mem_rdy = 1'b0;
  logic [31:0] mem_d = '0;
  logic        snp_wr = 1'b0;
  logic [25:0] snp_a = '0;
  logic        flush_req = 1'b0;
  logic        mem_req, wr, clr, all, busy, fill_done;
  logic [25:0] mem_a, wra;
  logic [31:0] wrd;
  logic [3:0]  wrm;

  l2_fill_ctrl #(.FLUSH_ENTRIES(FLUSH_N)) dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_a(miss_a),
    .mem_req(mem_req), .mem_a(mem_a), .mem_rdy(mem_rdy), .mem_d(mem_d),
    .snp_wr(snp_wr), .snp_a(snp_a), .flush_req(flush_req),
    .wra(wra), .wrd(wrd), .wrm(wrm), .wr(wr), .clr(clr), .all(all),
    .busy(busy), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] addr;
    logic [31:0] data;
    logic [3:0]  wrm;
    logic        clr;
    logic        all;
    logic        chk_data;
  } wr_t;

  typedef struct {
    logic [25:0] a;
    logic [31:0] d;
    int          lat;
    int          ph;      // snoop phase: 0 none, 1 fetch, 2 with MemRDY, 3 in FILL, 4 with MissReq in IDLE
    logic [25:0] s;
    logic        exp_clr;
    int          exp_nwr;
  } vec_t;

  wr_t  obs_q[$];
  wr_t  exp_q[$];
  wr_t  mon_w;
  vec_t vecs[8];
  int   tests = 0;
  int   fails = 0;
  logic snp_prev = 1'b0;

  always @(negedge clk) begin
    if (wr) begin
      mon_w.addr = wra; mon_w.data = wrd; mon_w.wrm = wrm;
      mon_w.clr = clr; mon_w.all = all; mon_w.chk_data = 1'b0;
      obs_q.push_back(mon_w);
    end
  end

  // The CPU bus never issues snoops on consecutive cycles.
  always @(posedge clk) begin
    if (rst_n) assert (!(snp_wr && snp_prev)) else $error("back-to-back snoop in stimulus");
    snp_prev <= snp_wr;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [25:0] a, input logic [31:0] d, input logic c, input logic f);
    wr_t w;
    w.addr = a; w.data = d; w.wrm = 4'hF; w.clr = c; w.all = 1'b0; w.chk_data = f;
    exp_q.push_back(w);
  endtask

  // Expected write-port traffic of one miss, from the fill/snoop rules.
  task automatic model_miss(input logic [25:0] a, input logic [31:0] d, input int ph, input logic [25:0] s);
    if (ph == 4 || ph == 1 || ph == 2) push_exp(s, 32'd0, 1'b1, 1'b0);
    push_exp(a, d, (ph >= 1 && ph <= 3) && (s == a), 1'b1);
    if (ph == 3) push_exp(s, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({tag, "_wr"}, {obs_q[i].addr, obs_q[i].clr, obs_q[i].all, obs_q[i].wrm},
            {exp_q[i].addr, exp_q[i].clr, exp_q[i].all, exp_q[i].wrm});
      if (exp_q[i].chk_data) check({tag, "_wrd"}, obs_q[i].data, exp_q[i].data);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_sweep(input string tag, input int start);
    int bad = 0;
    check({tag, "_nwr"}, obs_q.size(), start + FLUSH_N);
    for (int i = start; i < obs_q.size(); i++)
      if (obs_q[i].addr != 26'(i - start) || !obs_q[i].clr || !obs_q[i].all) bad++;
    check({tag, "_entries"}, bad, 0);
  endtask

  task automatic run_snoop(input logic [25:0] s);
    snp_wr = 1'b1; snp_a = s;
    step();
    snp_wr = 1'b0;
    check("idle_inval", {wr, clr, all, wra}, {3'b110, s});
    step();
    check("idle_inval_single", wr, 1'b0);
    $display("[TB] snoop s=%h", s);
  endtask

  task automatic run_miss(input logic [25:0] a, input logic [31:0] d, input int lat,
                          input int ph, input logic [25:0] s, input bit hold);
    int n;
    miss_req = 1'b1; miss_a = a;
    if (ph == 4) begin snp_wr = 1'b1; snp_a = s; end
    step();
    snp_wr = 1'b0;
    n = 1;
    while (!mem_req && n < 8) begin step(); n++; end
    check("miss_accept_lat", n, (ph == 4) ? 2 : 1);
    check("mem_a", mem_a, a);
    for (int k = 0; k < lat; k++) begin
      if (ph == 1 && k == 0) begin snp_wr = 1'b1; snp_a = s; end
      step();
      snp_wr = 1'b0;
      check("mem_req_held", mem_req, 1'b1);
    end
    mem_rdy = 1'b1; mem_d = d;
    if (ph == 2) begin snp_wr = 1'b1; snp_a = s; end
    step();
    mem_rdy = 1'b0; snp_wr = 1'b0;
    check("mem_req_drop", {mem_req, busy, fill_done}, 3'b010);
    if (ph == 3) begin snp_wr = 1'b1; snp_a = s; end
    step();
    snp_wr = 1'b0;
    check("fill_strobe", {wr, fill_done, wrm, wra}, {2'b11, 4'hF, a});
    if (!hold) miss_req = 1'b0;
    step();
    miss_req = 1'b0;
    if (ph == 3) check("queued_inval", {wr, clr, wra}, {2'b11, s});
    else check("idle_after_fill", {wr, fill_done}, 2'b00);
    step();
    check("no_refetch", {mem_req, busy, wr}, 3'b000);
    $display("[TB] miss a=%h d=%h lat=%0d ph=%0d s=%h hold=%0d", a, d, lat, ph, s, hold);
  endtask

  initial begin
    int n;
    int fi;
    logic [25:0] ra, rs;
    logic [31:0] rd;
    int rph, rlat;
    bit rhold;

    vecs[0] = '{26'h0012345, 32'hDEADBEEF, 3, 0, 26'h0,       1'b0, 1};
    vecs[1] = '{26'h0000100, 32'h11112222, 2, 1, 26'h0000100, 1'b1, 2};
    vecs[2] = '{26'h0000100, 32'h33334444, 2, 1, 26'h0000104, 1'b0, 2};
    vecs[3] = '{26'h3ABCDEF, 32'h55556666, 1, 2, 26'h3ABCDEF, 1'b1, 2};
    vecs[4] = '{26'h0000200, 32'h77778888, 2, 3, 26'h0000200, 1'b1, 2};
    vecs[5] = '{26'h0000200, 32'h9999AAAA, 2, 3, 26'h0000300, 1'b0, 2};
    vecs[6] = '{26'h0000400, 32'hBBBBCCCC, 1, 4, 26'h0000400, 1'b0, 2};
    vecs[7] = '{26'h3FFFFFF, 32'hFFFFFFFF, 0, 0, 26'h0,       1'b0, 1};

    // Reset held with requests active.
    rst_n = 1'b0; flush_req = 1'b1; miss_req = 1'b1; miss_a = 26'h0012345;
    repeat (3) step();
    check("reset_ctl", {mem_req, wr, clr, all, busy, fill_done, wrm}, 10'd0);
    check("reset_addr", {mem_a, wra}, 52'd0);
    check("reset_wrd", wrd, 32'd0);
    flush_req = 1'b0; miss_req = 1'b0;
    rst_n = 1'b1;
    repeat (5) step();
    mem_rdy = 1'b1; mem_d = 32'h12345678;
    step();
    mem_rdy = 1'b0;
    repeat (2) step();
    check("post_reset_quiet", {obs_q.size() == 0, busy, fill_done, mem_req}, 4'b1000);
    obs_q.delete();

    // Table of fill/snoop interactions.
    for (int i = 0; i < 8; i++) begin
      run_miss(vecs[i].a, vecs[i].d, vecs[i].lat, vecs[i].ph, vecs[i].s, 1'b1);
      fi = (vecs[i].ph == 1 || vecs[i].ph == 2 || vecs[i].ph == 4) ? 1 : 0;
      check("vec_nwr", obs_q.size(), vecs[i].exp_nwr);
      if (fi < obs_q.size())
        check("vec_fill", {obs_q[fi].addr, obs_q[fi].data, obs_q[fi].wrm, obs_q[fi].clr, obs_q[fi].all},
              {vecs[i].a, vecs[i].d, 4'hF, vecs[i].exp_clr, 1'b0});
      if (vecs[i].exp_nwr == 2 && obs_q.size() == 2)
        check("vec_inval", {obs_q[1 - fi].addr, obs_q[1 - fi].clr}, {vecs[i].s, 1'b1});
      obs_q.delete();
    end

    // Flush from IDLE: 1024 consecutive sweep writes.
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    check("flush_first_wr", {wr, clr, all, wra}, {3'b111, 26'd0});
    n = 0;
    while (busy && n < 2000) begin n++; step(); end
    check("flush_busy_cycles", n, FLUSH_N);
    check_sweep("flush_idle", 0);
    obs_q.delete();
    $display("[TB] flush from idle, busy=%0d cycles", n);

    // FlushReq during the sweep restarts the index.
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    repeat (9) step();
    check("flush_mid_idx", wra, 26'd9);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    check("flush_restart", {wr, wra}, {1'b1, 26'd0});
    n = 0;
    while (busy && n < 2000) begin n++; step(); end
    check("flush_restart_cycles", n, FLUSH_N);
    check("flush_restart_nwr", obs_q.size(), 10 + FLUSH_N);
    obs_q.delete();
    $display("[TB] flush restart");

    // FlushReq during FETCH: fill discarded, then sweep; a snoop in the sweep is dropped.
    miss_req = 1'b1; miss_a = 26'h0000777;
    step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    mem_rdy = 1'b1; mem_d = 32'hCAFEF00D;
    step();
    mem_rdy = 1'b0;
    step();
    check("flushfetch_fill", {wr, clr, fill_done, wrd, wra}, {3'b111, 32'hCAFEF00D, 26'h0000777});
    step();
    miss_req = 1'b0;
    check("flushfetch_sweep_start", {wr, all, busy, wra}, {3'b111, 26'd0});
    n = 0;
    while (busy && n < 2000) begin
      if (n == 100) begin snp_wr = 1'b1; snp_a = 26'h1234567; end
      step();
      snp_wr = 1'b0;
      n++;
    end
    check("flushfetch_busy_cycles", n, FLUSH_N);
    if (obs_q.size() > 0)
      check("flushfetch_obs_fill", {obs_q[0].addr, obs_q[0].clr, obs_q[0].all}, {26'h0000777, 2'b10});
    if (obs_q.size() > 0) void'(obs_q.pop_front());
    check_sweep("flushfetch", 0);
    check("flushfetch_no_refetch", mem_req, 1'b0);
    obs_q.delete();
    $display("[TB] flush during fetch");

    // Asynchronous reset in the middle of a fetch.
    miss_req = 1'b1; miss_a = 26'h0055AA0;
    step();
    check("midrst_fetch", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_async", {mem_req, busy, wr, fill_done, wrm, mem_a}, 34'd0);
    check("midrst_wrd", wrd, 32'd0);
    miss_req = 1'b0;
    step();
    rst_n = 1'b1;
    mem_rdy = 1'b1; mem_d = 32'h0BADF00D;
    step();
    mem_rdy = 1'b0;
    repeat (2) step();
    check("midrst_stray_rdy", {obs_q.size() == 0, fill_done, busy, mem_req}, 4'b1000);
    obs_q.delete();
    $display("[TB] async reset mid-fetch");

    // Randomized traffic against the write-list model.
    for (int it = 0; it < 150; it++) begin
      ra = 26'($urandom());
      rd = $urandom();
      if ($urandom_range(0, 3) == 0) begin
        run_snoop(ra);
        push_exp(ra, 32'd0, 1'b1, 1'b0);
        compare_writes("rnd_snoop");
      end else begin
        rs    = ($urandom_range(0, 1) == 1) ? ra : 26'($urandom());
        rph   = $urandom_range(0, 4);
        rlat  = $urandom_range(1, 4);
        rhold = 1'($urandom_range(0, 1));
        model_miss(ra, rd, rph, rs);
        run_miss(ra, rd, rlat, rph, rs, rhold);
        compare_writes("rnd_miss");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
